operand_stage: RTL and testbench
================================

# operand_stage

Operand-fetch stage directly upstream of `alu`: decodes an RV32I instruction word, reads the 32x32 integer register file, and registers the `alu` inputs `opCode`, `inpA` and `inpB`, plus destination info for writeback. It replaces direct operand wiring when the core runs with a registered ALU front end. Instructions and results are exchanged through valid/ready handshakes, and the writeback port updates the register file.

## Interface
- `XLEN`, 32: datapath width. Only 32 is supported.
- `clk`  in  1  rising-edge clock
- `rstN`  in  1  asynchronous active-low reset
- `inValid`  in  1  `inInst` holds a valid instruction
- `inReady`  out  1  stage accepts `inInst` this cycle
- `inInst`  in  32  RV32I instruction word
- `wbEn`  in  1  register-file write enable
- `wbAddr`  in  5  write register index
- `wbData`  in  32  write data
- `outValid`  out  1  output register holds a decoded instruction
- `outReady`  in  1  consumer takes the output this cycle
- `opCode`  out  4  ALU operation, fed to `alu.opCode`
- `inpA`  out  32  operand A, rs1 value
- `inpB`  out  32  operand B, rs2 value or immediate
- `rdAddr`  out  5  destination register index
- `rdWen`  out  1  result must be written back
- `illegal`  out  1  instruction not supported

## Operation
- **ALU encoding (fixed):**
  - 0000 ADD, 0001 SUB, 0010 SLL, 0011 XOR
  - 0100 SRL, 0101 SRA, 0110 OR, 0111 AND
  - 1000 SLT, 1001 BNE, 1010 SLTU, 1011 BEQ
  - 1100–1111 are unused.
- **R-type (opcode 0110011):**
  - `opCode` is selected by funct3/funct7. funct7 0100000 selects SUB (funct3 000) or SRA (funct3 101).
  - `inpB` = rs2. `rdWen` = (rd != 0).
- **I-type ALU (opcode 0010011):**
  - `inpB` is the sign-extended imm[11:0]. There is no SUBI.
  - SLLI/SRLI/SRAI: `inpB` = {27'b0, shamt}. A shift with inst[25] = 1 is illegal.
  - `rdWen` = (rd != 0).
- **Branch (opcode 1100011):**
  - funct3 000 gives BEQ and 001 gives BNE. Any other funct3 is illegal.
  - `inpB` = rs2, `rdWen` = 0, `rdAddr` = 0.
- **Illegal instructions:** any other opcode or funct combination.
  - Captured with `illegal` = 1, `opCode` = 0000, `inpA` = `inpB` = 0, `rdWen` = 0.
- **Register file:**
  - x0 reads 0 always. Writes to x0 are ignored.
  - Writes occur on the rising edge when `wbEn` = 1.
  - Reads are combinational and are captured into the output register.
- **Handshake:**
  - `inReady` = !`outValid` | `outReady`.
  - A transfer occurs when `inValid` & `inReady`.
  - While `outValid` & !`outReady`, all outputs hold stable.
- **Output update:**
  - When `outReady` = 1 and no new transfer occurs, `outValid` clears.
  - The data outputs keep their last value in that case.

## Timing
- **Reset:** asserting `rstN` low clears all 31 registers, `outValid`, `opCode`, `inpA`, `inpB`, `rdAddr`, `rdWen` and `illegal` to 0, asynchronously. `inReady` resets to 1.
- **Latency:** 1 cycle. An instruction accepted at edge N appears on the outputs after edge N.
- **Throughput:** 1 instruction per cycle while `outReady` = 1.
- **Writeback without forwarding:** a write in the same cycle as a read of the same register returns the old value, unless `WB_BYPASS_EN` is defined.
- **Writeback during stall:** `wbEn` is honoured regardless of handshake state. An already-captured operand is not updated.
- **Simultaneous accept and release:** the new entry replaces the old one in the same edge, and `outValid` stays 1.
- **Reset during stall:** the pending instruction is discarded.

## Configuration
- `WB_BYPASS_EN` defined:
  - When `wbEn` = 1, `wbAddr` != 0 and `wbAddr` equals rs1 or rs2 of the instruction being accepted, the captured operand is `wbData`.
  - This forwarding is combinational, within the same cycle.
- `WB_BYPASS_EN` undefined:
  - No forwarding. The captured operand is the pre-write value.
  - Upstream logic must insert one bubble to see the new value.

## Test plan
- **Reset:** reset, then write x5 = 0xD00000A5 and x6 = 0xF00000C3. Feed XOR x7,x5,x6 (0x0062C3B3) → `opCode` = 0011, `inpA` = 0xD00000A5, `inpB` = 0xF00000C3, `rdAddr` = 7, `rdWen` = 1, one cycle later.
- **I-type shift:** SRLI x1,x2,9 with x2 = 0x00000BD6 → `opCode` = 0100, `inpA` = 0xBD6, `inpB` = 9. ADDI x1,x0,-1 → `opCode` = 0000, `inpA` = 0, `inpB` = 0xFFFFFFFF.
- **Branch and x0:**
  - BNE x3,x4 with x3 = 0x00121182, x4 = 0x00111182 → `opCode` = 1001, `rdWen` = 0.
  - Write x0 = 0x1234, then ADD x1,x0,x0 → `inpA` = `inpB` = 0, `rdWen` = 1.
- **Backpressure:** hold `outReady` = 0 for 3 cycles with `inValid` = 1 → `inReady` = 0, outputs stable. Release `outReady` → the next instruction is captured on the same edge, with no loss or duplication.
- **Illegal:** LUI (0x000120B7) → `illegal` = 1, `opCode` = 0000, operands 0, `rdWen` = 0. SLLI with inst[25] = 1 → `illegal` = 1.
- **Same-cycle writeback and reset:**
  - With `wbEn` writing x5 = 0xAA in the accept cycle of ADD x1,x5,x0: `inpA` = 0xAA with `WB_BYPASS_EN`, and the old x5 without it.
  - Drop `rstN` mid-stall → `outValid` = 0 immediately and all registers read 0.

Source files
------------

// File: rtl/operand_stage.sv
// rtl/operand_stage.sv - RV32I operand-fetch stage feeding a registered ALU front end
//
// Decodes an RV32I instruction, reads the 32x32 register file and registers
// the ALU inputs plus writeback destination behind a valid/ready handshake.
//
// Ports:
//   clk, rstN              clock, asynchronous active-low reset
//   inValid/inReady/inInst instruction input handshake
//   wbEn/wbAddr/wbData     register-file write port (always honoured)
//   outValid/outReady      output register handshake
//   opCode, inpA, inpB     ALU operation and operands
//   rdAddr, rdWen          destination register and write-back request
//   illegal                instruction not supported
//
// Optional feature: define WB_BYPASS_EN to forward a same-cycle writeback
// into the operands of the instruction being accepted.

module operand_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rstN,
  input  logic            inValid,
  output logic            inReady,
  input  logic [31:0]     inInst,
  input  logic            wbEn,
  input  logic [4:0]      wbAddr,
  input  logic [XLEN-1:0] wbData,
  output logic            outValid,
  input  logic            outReady,
  output logic [3:0]      opCode,
  output logic [XLEN-1:0] inpA,
  output logic [XLEN-1:0] inpB,
  output logic [4:0]      rdAddr,
  output logic            rdWen,
  output logic            illegal
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_SLL  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SRL  = 4'b0100;
  localparam logic [3:0] OP_SRA  = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_BNE  = 4'b1001;
  localparam logic [3:0] OP_SLTU = 4'b1010;
  localparam logic [3:0] OP_BEQ  = 4'b1011;

  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_I   = 7'b0010011;
  localparam logic [6:0] OPC_BR  = 7'b1100011;
  localparam logic [6:0] F7_STD  = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Register file: x0 is not stored, it reads as zero.
  logic [XLEN-1:0] rf_q [1:31];

  logic            out_valid_q;
  logic [3:0]      op_q;
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;
  logic [4:0]      rd_q;
  logic            wen_q;
  logic            ill_q;

  logic [6:0]      opc;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      rd;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;

  logic [3:0]      op_d;
  logic [XLEN-1:0] a_d;
  logic [XLEN-1:0] b_d;
  logic [4:0]      rd_d;
  logic            wen_d;
  logic            ill_d;

  logic            transfer;

  assign opc = inInst[6:0];
  assign rd  = inInst[11:7];
  assign f3  = inInst[14:12];
  assign rs1 = inInst[19:15];
  assign rs2 = inInst[24:20];
  assign f7  = inInst[31:25];

  assign inReady  = !out_valid_q || outReady;
  assign transfer = inValid && inReady;

  // Combinational reads; the optional bypass lets a same-cycle write win.
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (rs1 != 5'd0) rs1_val = rf_q[rs1];
    if (rs2 != 5'd0) rs2_val = rf_q[rs2];
`ifdef WB_BYPASS_EN
    if (wbEn && (wbAddr != 5'd0) && (wbAddr == rs1)) rs1_val = wbData;
    if (wbEn && (wbAddr != 5'd0) && (wbAddr == rs2)) rs2_val = wbData;
`endif
  end

  always_comb begin
    op_d  = OP_ADD;
    a_d   = rs1_val;
    b_d   = rs2_val;
    rd_d  = rd;
    wen_d = (rd != 5'd0);
    ill_d = 1'b0;

    case (opc)
      OPC_R: begin
        if (f7 == F7_STD) begin
          case (f3)
            3'b000:  op_d = OP_ADD;
            3'b001:  op_d = OP_SLL;
            3'b010:  op_d = OP_SLT;
            3'b011:  op_d = OP_SLTU;
            3'b100:  op_d = OP_XOR;
            3'b101:  op_d = OP_SRL;
            3'b110:  op_d = OP_OR;
            default: op_d = OP_AND;
          endcase
        end else if (f7 == F7_ALT && f3 == 3'b000) begin
          op_d = OP_SUB;
        end else if (f7 == F7_ALT && f3 == 3'b101) begin
          op_d = OP_SRA;
        end else begin
          ill_d = 1'b1;
        end
      end
      OPC_I: begin
        b_d = {{(XLEN-12){inInst[31]}}, inInst[31:20]};
        case (f3)
          3'b000: op_d = OP_ADD;
          3'b010: op_d = OP_SLT;
          3'b011: op_d = OP_SLTU;
          3'b100: op_d = OP_XOR;
          3'b110: op_d = OP_OR;
          3'b111: op_d = OP_AND;
          3'b001: begin
            // Shift immediates carry only the 5-bit shamt; upper bits must be zero.
            b_d = {{(XLEN-5){1'b0}}, inInst[24:20]};
            if (f7 == F7_STD) op_d = OP_SLL;
            else              ill_d = 1'b1;
          end
          default: begin
            b_d = {{(XLEN-5){1'b0}}, inInst[24:20]};
            if (f7 == F7_STD)      op_d = OP_SRL;
            else if (f7 == F7_ALT) op_d = OP_SRA;
            else                   ill_d = 1'b1;
          end
        endcase
      end
      OPC_BR: begin
        rd_d  = 5'd0;
        wen_d = 1'b0;
        if (f3 == 3'b000)      op_d = OP_BEQ;
        else if (f3 == 3'b001) op_d = OP_BNE;
        else                   ill_d = 1'b1;
      end
      default: ill_d = 1'b1;
    endcase

    if (ill_d) begin
      op_d  = OP_ADD;
      a_d   = '0;
      b_d   = '0;
      rd_d  = 5'd0;
      wen_d = 1'b0;
    end
  end

  // Writeback is independent of the handshake.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 1; i < 32; i++) rf_q[i] <= '0;
    end else if (wbEn && (wbAddr != 5'd0)) begin
      rf_q[wbAddr] <= wbData;
    end
  end

  // Output register: data only changes on a transfer, so a stall holds it
  // and a release without a new instruction keeps the last values.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      out_valid_q <= 1'b0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rd_q        <= '0;
      wen_q       <= 1'b0;
      ill_q       <= 1'b0;
    end else if (transfer) begin
      out_valid_q <= 1'b1;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      rd_q        <= rd_d;
      wen_q       <= wen_d;
      ill_q       <= ill_d;
    end else if (outReady) begin
      out_valid_q <= 1'b0;
    end
  end

  assign outValid = out_valid_q;
  assign opCode   = op_q;
  assign inpA     = a_q;
  assign inpB     = b_q;
  assign rdAddr   = rd_q;
  assign rdWen    = wen_q;
  assign illegal  = ill_q;

endmodule

// File: tb/tb_operand_stage.sv
// tb/tb_operand_stage.sv - self-checking bench for operand_stage

module tb_operand_stage;

  logic        clk = 1'b0;
  logic        rstN;
  logic        inValid;
  logic        inReady;
  logic [31:0] inInst;
  logic        wbEn;
  logic [4:0]  wbAddr;
  logic [31:0] wbData;
  logic        outValid;
  logic        outReady;
  logic [3:0]  opCode;
  logic [31:0] inpA;
  logic [31:0] inpB;
  logic [4:0]  rdAddr;
  logic        rdWen;
  logic        illegal;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  operand_stage #(.XLEN(32)) dut (
    .clk(clk), .rstN(rstN),
    .inValid(inValid), .inReady(inReady), .inInst(inInst),
    .wbEn(wbEn), .wbAddr(wbAddr), .wbData(wbData),
    .outValid(outValid), .outReady(outReady),
    .opCode(opCode), .inpA(inpA), .inpB(inpB),
    .rdAddr(rdAddr), .rdWen(rdWen), .illegal(illegal)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        wen;
    logic        ill;
  } dec_t;

  // ALU code for funct3 of plain R-type / I-type arithmetic.
  int base_op [8] = '{0, 2, 8, 10, 3, 4, 6, 7};

  function automatic dec_t model_decode(input logic [31:0] ins, input logic [31:0] va,
                                        input logic [31:0] vb);
    dec_t d;
    int   op = -1;
    logic [6:0] opc = ins[6:0];
    logic [2:0] f3  = ins[14:12];
    logic [6:0] f7  = ins[31:25];
    d.a   = va;
    d.b   = vb;
    d.rd  = ins[11:7];
    d.wen = (ins[11:7] != 0);
    d.ill = 1'b0;
    if (opc == 7'h33) begin
      if (f7 == 7'h00) op = base_op[f3];
      else if (f7 == 7'h20 && f3 == 3'd0) op = 1;
      else if (f7 == 7'h20 && f3 == 3'd5) op = 5;
    end else if (opc == 7'h13) begin
      if (f3 == 3'd1) begin
        d.b = 32'(ins[24:20]);
        if (f7 == 7'h00) op = 2;
      end else if (f3 == 3'd5) begin
        d.b = 32'(ins[24:20]);
        if (f7 == 7'h00) op = 4;
        else if (f7 == 7'h20) op = 5;
      end else begin
        d.b = 32'($signed(ins[31:20]));
        op  = base_op[f3];
      end
    end else if (opc == 7'h63) begin
      d.rd  = 0;
      d.wen = 0;
      if (f3 == 3'd0) op = 11;
      else if (f3 == 3'd1) op = 9;
    end
    if (op < 0) begin
      d = '0;
      d.ill = 1'b1;
    end else begin
      d.op = 4'(op);
    end
    return d;
  endfunction

  logic [31:0] m_rf [32];
  logic        m_valid;
  dec_t        m_out;

  function automatic logic [31:0] m_read(input logic [4:0] r);
    if (r == 0) return 32'h0;
`ifdef WB_BYPASS_EN
    if (wbEn && wbAddr == r) return wbData;
`endif
    return m_rf[r];
  endfunction

  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
      m_valid = 1'b0;
      m_out   = '0;
    end else begin
      if (inValid && (!m_valid || outReady)) begin
        m_out   = model_decode(inInst, m_read(inInst[19:15]), m_read(inInst[24:20]));
        m_valid = 1'b1;
      end else if (outReady) begin
        m_valid = 1'b0;
      end
      if (wbEn && wbAddr != 0) m_rf[wbAddr] = wbData;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (rstN) begin
      chk("outValid", 32'(outValid), 32'(m_valid));
      chk("inReady", 32'(inReady), 32'(!m_valid || outReady));
      chk("opCode", 32'(opCode), 32'(m_out.op));
      chk("inpA", inpA, m_out.a);
      chk("inpB", inpB, m_out.b);
      chk("rdWen", 32'(rdWen), 32'(m_out.wen));
      chk("illegal", 32'(illegal), 32'(m_out.ill));
      if (!m_out.ill) chk("rdAddr", 32'(rdAddr), 32'(m_out.rd));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic v, input logic [31:0] ins, input logic ordy,
                      input logic we, input logic [4:0] wa, input logic [31:0] wd);
    #1;
    inValid  = v;
    inInst   = ins;
    outReady = ordy;
    wbEn     = we;
    wbAddr   = wa;
    wbData   = wd;
    @(negedge clk);
  endtask

  task automatic wr(input logic [4:0] wa, input logic [31:0] wd);
    step(1'b0, 32'h0, 1'b1, 1'b1, wa, wd);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] r = $urandom;
    logic [6:0]  f7;
    case ($urandom_range(0, 4))
      0: begin
        f7 = ($urandom_range(0, 3) == 0) ? 7'($urandom) : (($urandom % 2) ? 7'h20 : 7'h00);
        return {f7, r[24:7], 7'h33};
      end
      1: return {r[31:7], 7'h13};
      2: begin
        case ($urandom_range(0, 2))
          0: f7 = 7'h00;
          1: f7 = 7'h20;
          default: f7 = 7'h01;
        endcase
        return {f7, r[24:15], (($urandom % 2) ? 3'd1 : 3'd5), r[11:7], 7'h13};
      end
      3: return {r[31:7], 7'h63};
      default: return r;
    endcase
  endfunction

  localparam logic [31:0] I_XOR   = 32'h0062C3B3;
  localparam logic [31:0] I_SRLI  = 32'h00915093;
  localparam logic [31:0] I_ADDI  = 32'hFFF00093;
  localparam logic [31:0] I_BNE   = 32'h00419063;
  localparam logic [31:0] I_ADD00 = 32'h000000B3;
  localparam logic [31:0] I_LUI   = 32'h000120B7;
  localparam logic [31:0] I_SLLIB = 32'h02111093;
  localparam logic [31:0] I_ADD50 = 32'h000280B3;

  initial begin
    rstN = 1'b0; inValid = 0; inInst = 0; outReady = 1; wbEn = 0; wbAddr = 0; wbData = 0;
    repeat (2) @(negedge clk);
    chk("rst_outValid", 32'(outValid), 32'h0);
    chk("rst_inReady", 32'(inReady), 32'h1);
    chk("rst_opCode", 32'(opCode), 32'h0);
    chk("rst_inpA", inpA, 32'h0);
    chk("rst_inpB", inpB, 32'h0);
    chk("rst_rdWen", 32'(rdWen), 32'h0);
    chk("rst_illegal", 32'(illegal), 32'h0);
    #1 rstN = 1'b1;

    wr(5, 32'hD00000A5);
    wr(6, 32'hF00000C3);
    step(1, I_XOR, 1, 0, 0, 0);
    chk("xor_valid", 32'(outValid), 32'h1);
    chk("xor_op", 32'(opCode), 32'h3);
    chk("xor_a", inpA, 32'hD00000A5);
    chk("xor_b", inpB, 32'hF00000C3);
    chk("xor_rd", 32'(rdAddr), 32'd7);
    chk("xor_wen", 32'(rdWen), 32'h1);

    wr(2, 32'h00000BD6);
    step(1, I_SRLI, 1, 0, 0, 0);
    chk("srli_op", 32'(opCode), 32'h4);
    chk("srli_a", inpA, 32'h00000BD6);
    chk("srli_b", inpB, 32'd9);
    step(1, I_ADDI, 1, 0, 0, 0);
    chk("addi_op", 32'(opCode), 32'h0);
    chk("addi_a", inpA, 32'h0);
    chk("addi_b", inpB, 32'hFFFFFFFF);

    wr(3, 32'h00121182);
    wr(4, 32'h00111182);
    step(1, I_BNE, 1, 0, 0, 0);
    chk("bne_op", 32'(opCode), 32'h9);
    chk("bne_wen", 32'(rdWen), 32'h0);
    chk("bne_a", inpA, 32'h00121182);

    wr(0, 32'h1234);
    step(1, I_ADD00, 1, 0, 0, 0);
    chk("x0_a", inpA, 32'h0);
    chk("x0_b", inpB, 32'h0);
    chk("x0_wen", 32'(rdWen), 32'h1);

    step(1, I_LUI, 1, 0, 0, 0);
    chk("lui_ill", 32'(illegal), 32'h1);
    chk("lui_op", 32'(opCode), 32'h0);
    chk("lui_a", inpA, 32'h0);
    chk("lui_wen", 32'(rdWen), 32'h0);
    step(1, I_SLLIB, 1, 0, 0, 0);
    chk("slli25_ill", 32'(illegal), 32'h1);

    // Backpressure: stall three cycles, then release with the next instruction waiting.
    step(0, 0, 1, 0, 0, 0);
    step(1, I_XOR, 0, 0, 0, 0);
    chk("bp_first_op", 32'(opCode), 32'h3);
    for (int i = 0; i < 3; i++) begin
      step(1, I_SRLI, 0, 0, 0, 0);
      chk("bp_inReady", 32'(inReady), 32'h0);
      chk("bp_hold_op", 32'(opCode), 32'h3);
      chk("bp_hold_a", inpA, 32'hD00000A5);
    end
    step(1, I_SRLI, 1, 0, 0, 0);
    chk("bp_rel_valid", 32'(outValid), 32'h1);
    chk("bp_rel_op", 32'(opCode), 32'h4);
    step(0, 0, 1, 0, 0, 0);
    chk("bp_drain_valid", 32'(outValid), 32'h0);
    chk("bp_drain_hold", 32'(opCode), 32'h4);

    step(1, I_ADD50, 1, 1, 5, 32'h000000AA);
`ifdef WB_BYPASS_EN
    chk("wb_same_cycle", inpA, 32'h000000AA);
`else
    chk("wb_same_cycle", inpA, 32'hD00000A5);
`endif

    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 3) != 0), rand_inst(), ($urandom_range(0, 3) != 0),
           1'($urandom), 5'($urandom), $urandom);
    end

    // Reset in the middle of a stall.
    step(0, 0, 1, 0, 0, 0);
    step(1, I_XOR, 0, 0, 0, 0);
    step(1, I_XOR, 0, 0, 0, 0);
    #2 rstN = 1'b0;
    #1;
    chk("rst_stall_valid", 32'(outValid), 32'h0);
    chk("rst_stall_ready", 32'(inReady), 32'h1);
    step(0, 0, 1, 0, 0, 0);
    #1 rstN = 1'b1;
    step(1, I_XOR, 1, 0, 0, 0);
    chk("post_rst_a", inpA, 32'h0);
    chk("post_rst_b", inpB, 32'h0);
    chk("post_rst_op", 32'(opCode), 32'h3);
    step(0, 0, 1, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
